muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit executing MULT, MULTU, DIV and DIVU for the 54-instruction CPU. It sits directly upstream of the HI and LO registers. It takes rs/rt operands from the datapath, computes a 64-bit product or a quotient/remainder pair over 34 cycles, and drives the HI/LO data inputs and write enables with a one-cycle strobe. The controller stalls on `busy`.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Bundle between the CPU controller/datapath and the multiply/divide unit.
// The controller (master) issues operations and consumes the HI/LO write
// strobes. The unit (slave) produces the results.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        hi_wea;
  logic        lo_wea;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi_out, lo_out, hi_wea, lo_wea
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi_out, lo_out, hi_wea, lo_wea
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit feeding the HI and LO registers.
// Operation: one cycle to accept, 32 shift-add or restoring-divide iterations,
// one sign-fix cycle, and one cycle in which done and the write strobes are high.
// Signed operations run on magnitudes. The sign is applied in the fix cycle.
// A divide by zero skips the iterations and reports div_zero without writing.
module muldiv_unit (
  input  logic            clk,
  input  logic            rst,
  muldiv_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation helpers (wrap naturally on the most negative value)
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole 64-bit product right.
  function automatic logic [63:0] mul_step(input logic [31:0] hi,
                                           input logic [31:0] lo,
                                           input logic [31:0] mcand);
    logic [32:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    return {sum[32:1], sum[0], lo[31:1]};
  endfunction

  // One restoring-divide step: shift the next dividend bit (MSB first) into
  // the partial remainder and subtract the divisor if the result fits.
  // The remainder is always below the divisor, so the post-subtract value
  // fits in 32 bits and modular subtraction gives it exactly.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] shifted;
    logic        fits;
    shifted = {rem, quo[31]};
    fits    = shifted[32] | (shifted[31:0] >= dvs);
    if (fits) begin
      return {shifted[31:0] - dvs, quo[30:0], 1'b1};
    end
    return {shifted[31:0], quo[30:0], 1'b0};
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_acc_q, hi_acc_d;
  logic [31:0] lo_acc_q, lo_acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic        hi_wea_q, hi_wea_d;
  logic        lo_wea_q, lo_wea_d;
  logic [31:0] hi_out_q, hi_out_d;
  logic [31:0] lo_out_q, lo_out_d;

  logic        in_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] mul_nxt;
  logic [63:0] div_nxt;
  logic [63:0] prod_fix;

  // Operand magnitudes and per-iteration datapath results
  assign in_signed = ~bus.op[0];
  assign abs_a     = (in_signed && bus.a[31]) ? neg32(bus.a) : bus.a;
  assign abs_b     = (in_signed && bus.b[31]) ? neg32(bus.b) : bus.b;
  assign mul_nxt   = mul_step(hi_acc_q, lo_acc_q, opnd_q);
  assign div_nxt   = div_step(hi_acc_q, lo_acc_q, opnd_q);
  assign prod_fix  = neg_res_q ? neg64({hi_acc_q, lo_acc_q}) : {hi_acc_q, lo_acc_q};

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_acc_d   = hi_acc_q;
    lo_acc_d   = lo_acc_q;
    opnd_d     = opnd_q;
    hi_out_d   = hi_out_q;
    lo_out_d   = lo_out_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_wea_d   = 1'b0;
    lo_wea_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d  = bus.op[1];
          neg_res_d = in_signed & (bus.a[31] ^ bus.b[31]);
          neg_rem_d = in_signed & bus.a[31];
          hi_acc_d  = 32'd0;
          cnt_d     = 5'd0;
          if (bus.op[1]) begin
            lo_acc_d = abs_a;
            opnd_d   = abs_b;
          end else begin
            lo_acc_d = abs_b;
            opnd_d   = abs_a;
          end
          if (bus.op[1] && (bus.b == 32'd0)) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          {hi_acc_d, lo_acc_d} = div_nxt;
        end else begin
          {hi_acc_d, lo_acc_d} = mul_nxt;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_out_d = neg_res_q ? neg32(lo_acc_q) : lo_acc_q;
          hi_out_d = neg_rem_q ? neg32(hi_acc_q) : hi_acc_q;
        end else begin
          {hi_out_d, lo_out_d} = prod_fix;
        end
        state_d  = S_DONE;
        done_d   = 1'b1;
        hi_wea_d = 1'b1;
        lo_wea_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered-output flops; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_acc_q   <= 32'd0;
      lo_acc_q   <= 32'd0;
      opnd_q     <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_wea_q   <= 1'b0;
      lo_wea_q   <= 1'b0;
      hi_out_q   <= 32'd0;
      lo_out_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_acc_q   <= hi_acc_d;
      lo_acc_q   <= lo_acc_d;
      opnd_q     <= opnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_wea_q   <= hi_wea_d;
      lo_wea_q   <= lo_wea_d;
      hi_out_q   <= hi_out_d;
      lo_out_q   <= lo_out_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_wea   = hi_wea_q;
  assign bus.lo_wea   = lo_wea_q;
  assign bus.hi_out   = hi_out_q;
  assign bus.lo_out   = lo_out_q;

endmodule
